// File: rtl/uart_reg8to24.sv
// Receive-side byte packer: gathers up to three UART bytes into a 32-bit bus word
// ([23:0] data, [27:26] byte count) behind a one-word output holding register.
module uart_reg8to24 #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        rden,
    output logic [31:0] dout,
    output logic        valid,
    output logic        overflow,
    input  logic        clr_overflow
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] TMO = IW'(TIMEOUT_CYCLES);

    logic [23:0]   acc_q, acc_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [31:0]   out_word_q, out_word_d;
    logic          valid_q, valid_d;
    logic          overflow_q, overflow_d;
    logic          flush_req, slot_free;

    assign flush_req = (acc_cnt_q == 2'd3) || ((acc_cnt_q != 2'd0) && (idle_cnt_q == TMO));
    assign slot_free = !valid_q || rden;

    always_comb begin
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;
        idle_cnt_d = idle_cnt_q;
        out_word_d = out_word_q;
        valid_d    = valid_q;
        overflow_d = clr_overflow ? 1'b0 : overflow_q;

        if (flush_req && slot_free) begin
            out_word_d = {4'b0, acc_cnt_q, 2'b0, acc_q};
            valid_d    = 1'b1;
            idle_cnt_d = '0;
            // A byte arriving on the flush edge starts the next word, so streaming never drops.
            if (din_valid) begin
                acc_d     = {16'b0, din};
                acc_cnt_d = 2'd1;
            end else begin
                acc_d     = '0;
                acc_cnt_d = 2'd0;
            end
        end else if (din_valid && (acc_cnt_q != 2'd3)) begin
            case (acc_cnt_q)
                2'd0:    acc_d[7:0]   = din;
                2'd1:    acc_d[15:8]  = din;
                default: acc_d[23:16] = din;
            endcase
            acc_cnt_d  = acc_cnt_q + 2'd1;
            idle_cnt_d = '0;
            if (rden) valid_d = 1'b0;
        end else if (din_valid) begin
            // Accumulator full and the output slot is occupied: the byte has nowhere to go.
            overflow_d = 1'b1;
            if (rden) valid_d = 1'b0;
        end else begin
            if (acc_cnt_q == 2'd0) begin
                idle_cnt_d = '0;
            end else if ((acc_cnt_q != 2'd3) && (idle_cnt_q != TMO)) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
            if (rden && valid_q) valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            acc_cnt_q  <= '0;
            idle_cnt_q <= '0;
            out_word_q <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            out_word_q <= out_word_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign dout     = out_word_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_uart_reg8to24.sv
// Directed bench for uart_reg8to24 with a short timeout so idle flushes are quick to reach.
module tb_uart_reg8to24;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        rden = 1'b0;
    logic        clr_overflow = 1'b0;
    logic [31:0] dout;
    logic        valid;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    uart_reg8to24 #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (din_valid),
        .rden         (rden),
        .dout         (dout),
        .valid        (valid),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are stable 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        din = b;
        din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
        din = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++;
        if (dout !== 32'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 00000000", dout); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_full_word();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL full_early: got valid %b want 0", valid); end
        cyc();
        n_cmp++;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b want 1", valid); end
        n_cmp++;
        if (dout !== 32'h0C332211) begin n_bad++; $display("FAIL full_dout: got %h want 0C332211", dout); end
        rden = 1'b1;
        cyc();
        rden = 1'b0;
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL full_read_valid: got %b want 0", valid); end
        n_cmp++;
        if (dout !== 32'h0C332211) begin n_bad++; $display("FAIL full_read_hold: got %h want 0C332211", dout); end
    endtask

    task automatic test_timeout();
        send(8'hAA);
        send(8'hBB);
        for (int i = 1; i <= TMO + 1; i++) begin
            cyc();
            if (i <= TMO) begin
                n_cmp++;
                if (valid !== 1'b0) begin n_bad++; $display("FAIL tmo_early[%0d]: got valid %b want 0", i, valid); end
            end
        end
        n_cmp++;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL tmo_valid: got %b want 1", valid); end
        n_cmp++;
        if (dout !== 32'h0800BBAA) begin n_bad++; $display("FAIL tmo_dout: got %h want 0800BBAA", dout); end
        rden = 1'b1;
        cyc();
        rden = 1'b0;
    endtask

    task automatic test_overflow();
        send(8'h10);
        send(8'h20);
        send(8'h30);
        cyc();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_cmp++;
        if (dout !== 32'h0C302010) begin n_bad++; $display("FAIL ovf_hold_dout: got %h want 0C302010", dout); end
        n_cmp++;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL ovf_hold_valid: got %b want 1", valid); end
        // A drop in the same cycle as a clear keeps the flag set.
        clr_overflow = 1'b1;
        send(8'h05);
        clr_overflow = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_drop_vs_clr: got %b want 1", overflow); end
        rden = 1'b1;
        cyc();
        n_cmp++;
        if (dout !== 32'h0C030201) begin n_bad++; $display("FAIL ovf_second_word: got %h want 0C030201", dout); end
        n_cmp++;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL ovf_second_valid: got %b want 1", valid); end
        cyc();
        rden = 1'b0;
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", valid); end
        for (int i = 0; i < TMO + 2; i++) cyc();
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL ovf_lost_byte: got valid %b want 0 (dout %h)", valid, dout); end
        clr_overflow = 1'b1;
        cyc();
        clr_overflow = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        cyc();
        send(8'hB1);
        send(8'hB2);
        send(8'hB3);
        n_cmp++;
        if (dout !== 32'h0CA3A2A1) begin n_bad++; $display("FAIL b2b_first: got %h want 0CA3A2A1", dout); end
        din = 8'h55;
        din_valid = 1'b1;
        rden = 1'b1;
        cyc();
        din_valid = 1'b0;
        rden = 1'b0;
        n_cmp++;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", valid); end
        n_cmp++;
        if (dout !== 32'h0CB3B2B1) begin n_bad++; $display("FAIL b2b_second: got %h want 0CB3B2B1", dout); end
        send(8'h66);
        send(8'h77);
        rden = 1'b1;
        cyc();
        n_cmp++;
        if (dout !== 32'h0C776655) begin n_bad++; $display("FAIL b2b_third: got %h want 0C776655", dout); end
        n_cmp++;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL b2b_third_valid: got %b want 1", valid); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_no_drop: got overflow %b want 0", overflow); end
        cyc();
        rden = 1'b0;
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", valid); end
    endtask

    task automatic test_reset_mid();
        send(8'h01);
        send(8'h02);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (dout !== 32'h0) begin n_bad++; $display("FAIL rstmid_dout: got %h want 00000000", dout); end
        for (int i = 0; i < TMO + 3; i++) cyc();
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale: got valid %b want 0", valid); end
        send(8'h77);
        send(8'h88);
        send(8'h99);
        cyc();
        n_cmp++;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_valid: got %b want 1", valid); end
        n_cmp++;
        if (dout !== 32'h0C998877) begin n_bad++; $display("FAIL rstmid_dout2: got %h want 0C998877", dout); end
    endtask

    task automatic test_rden_idle();
        rden = 1'b1;
        cyc();
        rden = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            rden = 1'b1;
            cyc();
            rden = 1'b0;
            n_cmp++;
            if (valid !== 1'b0) begin n_bad++; $display("FAIL idle_rd_valid[%0d]: got %b want 0", i, valid); end
            n_cmp++;
            if (dout !== 32'h0C998877) begin n_bad++; $display("FAIL idle_rd_dout[%0d]: got %h want 0C998877", i, dout); end
        end
        send(8'h42);
        for (int i = 0; i < TMO + 1; i++) cyc();
        n_cmp++;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL idle_single_valid: got %b want 1", valid); end
        n_cmp++;
        if (dout !== 32'h04000042) begin n_bad++; $display("FAIL idle_single_dout: got %h want 04000042", dout); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_rden_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
